address_gen3: RTL and testbench



---
 rtl/address_gen3_pkg.sv | 17 +
 rtl/addr_gen_loop_counter.sv | 33 +++
 rtl/address_gen3.sv | 212 +++++++++++++++++++++
 tb/tb_address_gen3.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/address_gen3_pkg.sv
// Shared types and helpers for the address_gen3 three-level address generator.
package address_gen3_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_e;

    // A programmed count of zero behaves like a count of one.
    function automatic logic [31:0] zero_as_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/addr_gen_loop_counter.sv
// One loop level of the address nest: counts 0..max_i, wraps to zero, flags the last count.
module addr_gen_loop_counter #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == max_i);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/address_gen3.sv
// Three-level nested-loop address generator with start delay and valid/ready handshake.
// Define ADDRGEN3_DUTY_EN to gate valid_o with the level-1 duty count.
module address_gen3
    import address_gen3_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PERIOD_W = 10,
    parameter int unsigned DELAY_W  = 7
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                ignore_first_i,
    input  logic [PERIOD_W-1:0] per_i,
    input  logic [PERIOD_W-1:0] per2_i,
    input  logic [PERIOD_W-1:0] per3_i,
    input  logic [PERIOD_W-1:0] duty_i,
    input  logic [DELAY_W-1:0]  delay_i,
    input  logic [ADDR_W-1:0]   start_i,
    input  logic [ADDR_W-1:0]   incr_i,
    input  logic [ADDR_W-1:0]   incr2_i,
    input  logic [ADDR_W-1:0]   incr3_i,
    input  logic [ADDR_W-1:0]   iter_i,
    input  logic [ADDR_W-1:0]   iter2_i,
    input  logic [ADDR_W-1:0]   iter3_i,
    input  logic [ADDR_W-1:0]   shift_i,
    input  logic [ADDR_W-1:0]   shift2_i,
    input  logic [ADDR_W-1:0]   shift3_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                store_o,
    output logic                done_o
);

    state_e              state_q, state_d;
    logic [DELAY_W-1:0]  dly_q, dly_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d, store_q, store_d, done_q, done_d, ign_q, ign_d;

    logic [PERIOD_W-1:0] per_m_q, per2_m_q, per3_m_q;
    logic [ADDR_W-1:0]   it_m_q, it2_m_q, it3_m_q;
    logic [ADDR_W-1:0]   start_q, incr_q, incr2_q, incr3_q, shift_q, shift2_q, shift3_q;
    logic                ign_cfg_q;

    logic [PERIOD_W-1:0] per_m_in_c, p1_cnt, p1_nxt_c;
    logic [ADDR_W-1:0]   step_c, f_start_c;
    logic                l1, l2, l3, l4, l5, l6, all_last_c, adv_c, gate_c;
    logic                f_ign_c, f_store_c;

    // Outer counters only matter through their last flags.
    logic [ADDR_W-1:0]   it1_cnt_unused, it2_cnt_unused, it3_cnt_unused;
    logic [PERIOD_W-1:0] p2_cnt_unused, p3_cnt_unused;
    logic [DATA_W-1:0]   data_unused;

    assign data_unused = '0;
    assign per_m_in_c  = PERIOD_W'(zero_as_one(32'(per_i)) - 32'd1);

    // Configuration snapshot taken on run_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per_m_q <= '0; per2_m_q <= '0; per3_m_q <= '0;
            it_m_q  <= '0; it2_m_q  <= '0; it3_m_q  <= '0;
            start_q <= '0; incr_q   <= '0; incr2_q  <= '0; incr3_q <= '0;
            shift_q <= '0; shift2_q <= '0; shift3_q <= '0;
            ign_cfg_q <= 1'b0;
        end else if (run_i) begin
            per_m_q   <= per_m_in_c;
            per2_m_q  <= PERIOD_W'(zero_as_one(32'(per2_i)) - 32'd1);
            per3_m_q  <= PERIOD_W'(zero_as_one(32'(per3_i)) - 32'd1);
            it_m_q    <= ADDR_W'(zero_as_one(32'(iter_i)) - 32'd1);
            it2_m_q   <= ADDR_W'(zero_as_one(32'(iter2_i)) - 32'd1);
            it3_m_q   <= ADDR_W'(zero_as_one(32'(iter3_i)) - 32'd1);
            start_q   <= start_i;
            incr_q    <= incr_i;   incr2_q  <= incr2_i;  incr3_q  <= incr3_i;
            shift_q   <= shift_i;  shift2_q <= shift2_i; shift3_q <= shift3_i;
            ign_cfg_q <= ignore_first_i;
        end
    end

`ifdef ADDRGEN3_DUTY_EN
    logic [PERIOD_W-1:0] duty_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)      duty_q <= '0;
        else if (run_i) duty_q <= duty_i;
    end
    assign gate_c = (duty_q == '0) || (p1_nxt_c < duty_q);
`else
    logic duty_unused;
    assign duty_unused = ^duty_i;
    assign gate_c      = 1'b1;
`endif

    addr_gen_loop_counter #(.W(PERIOD_W)) u_per (.clk_i(clk_i), .rst_i(rst_i), .clr_i(run_i),
        .en_i(adv_c), .max_i(per_m_q), .cnt_o(p1_cnt), .last_o(l1));
    addr_gen_loop_counter #(.W(ADDR_W)) u_iter (.clk_i(clk_i), .rst_i(rst_i), .clr_i(run_i),
        .en_i(adv_c & l1), .max_i(it_m_q), .cnt_o(it1_cnt_unused), .last_o(l2));
    addr_gen_loop_counter #(.W(PERIOD_W)) u_per2 (.clk_i(clk_i), .rst_i(rst_i), .clr_i(run_i),
        .en_i(adv_c & l1 & l2), .max_i(per2_m_q), .cnt_o(p2_cnt_unused), .last_o(l3));
    addr_gen_loop_counter #(.W(ADDR_W)) u_iter2 (.clk_i(clk_i), .rst_i(rst_i), .clr_i(run_i),
        .en_i(adv_c & l1 & l2 & l3), .max_i(it2_m_q), .cnt_o(it2_cnt_unused), .last_o(l4));
    addr_gen_loop_counter #(.W(PERIOD_W)) u_per3 (.clk_i(clk_i), .rst_i(rst_i), .clr_i(run_i),
        .en_i(adv_c & l1 & l2 & l3 & l4), .max_i(per3_m_q), .cnt_o(p3_cnt_unused), .last_o(l5));
    addr_gen_loop_counter #(.W(ADDR_W)) u_iter3 (.clk_i(clk_i), .rst_i(rst_i), .clr_i(run_i),
        .en_i(adv_c & l1 & l2 & l3 & l4 & l5), .max_i(it3_m_q), .cnt_o(it3_cnt_unused), .last_o(l6));

    assign all_last_c = l1 & l2 & l3 & l4 & l5 & l6;
    assign p1_nxt_c   = l1 ? '0 : p1_cnt + PERIOD_W'(1);

    // Innermost non-wrapping level decides the step.
    always_comb begin
        step_c = shift3_q;
        if      (!l1) step_c = incr_q;
        else if (!l2) step_c = shift_q;
        else if (!l3) step_c = incr2_q;
        else if (!l4) step_c = shift2_q;
        else if (!l5) step_c = incr3_q;
    end

    // First beat comes straight from the ports when delay_i is zero.
    assign f_ign_c   = run_i ? ignore_first_i : ign_cfg_q;
    assign f_start_c = run_i ? start_i : start_q;
    assign f_store_c = !f_ign_c && (run_i ? (per_m_in_c == '0) : (per_m_q == '0));

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        store_d = store_q;
        done_d  = done_q;
        ign_d   = ign_q;
        adv_c   = 1'b0;
        if (run_i) begin
            done_d = 1'b0;
            if (delay_i == '0) begin
                state_d = RUN;
                addr_d  = f_start_c;
                ign_d   = f_ign_c;
                valid_d = !f_ign_c;
                store_d = f_store_c;
            end else begin
                state_d = DELAY;
                dly_d   = delay_i - DELAY_W'(1);
                valid_d = 1'b0;
                store_d = 1'b0;
                ign_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                DELAY: begin
                    if (dly_q == '0) begin
                        state_d = RUN;
                        addr_d  = f_start_c;
                        ign_d   = f_ign_c;
                        valid_d = !f_ign_c;
                        store_d = f_store_c;
                    end else begin
                        dly_d = dly_q - DELAY_W'(1);
                    end
                end
                RUN: begin
                    if (ign_q) begin
                        ign_d   = 1'b0;
                        valid_d = 1'b1;
                        store_d = (per_m_q == '0);
                    end else if (!valid_q || ready_i) begin
                        adv_c = 1'b1;
                        if (all_last_c) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            store_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + step_c;
                            valid_d = gate_c;
                            store_d = (p1_nxt_c == per_m_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            dly_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            store_q <= 1'b0;
            done_q  <= 1'b1;
            ign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            store_q <= store_d;
            done_q  <= done_d;
            ign_q   <= ign_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign store_o = store_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_address_gen3.sv
// Self-checking bench for address_gen3: directed tables, hand sequences and a randomized loop-nest model.
module tb_address_gen3;

    typedef struct {
        logic       ign;
        logic [9:0] per, per2, per3, duty;
        logic [6:0] delay;
        logic [9:0] start, incr, incr2, incr3, iter, iter2, iter3, shift, shift2, shift3;
    } cfg_t;

    typedef struct {
        logic [9:0] addr;
        logic       valid;
        logic       store;
        logic       chk_addr;
    } beat_t;

    typedef struct {
        int         scen;
        logic [9:0] addr;
        logic       valid;
        logic       store;
    } vec_t;

`ifdef ADDRGEN3_DUTY_EN
    localparam logic GAP_V = 1'b0;
`else
    localparam logic GAP_V = 1'b1;
`endif

    logic clk = 1'b0, rst = 1'b1, run = 1'b0, ign = 1'b0, ready = 1'b1;
    logic [9:0] per = '0, per2 = '0, per3 = '0, duty = '0;
    logic [6:0] delay = '0;
    logic [9:0] start = '0, incr = '0, incr2 = '0, incr3 = '0;
    logic [9:0] iter = '0, iter2 = '0, iter3 = '0, shift = '0, shift2 = '0, shift3 = '0;
    logic       valid, store, done;
    logic [9:0] addr;

    int errors = 0;
    int checks = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    address_gen3 dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .ignore_first_i(ign),
        .per_i(per), .per2_i(per2), .per3_i(per3), .duty_i(duty), .delay_i(delay),
        .start_i(start), .incr_i(incr), .incr2_i(incr2), .incr3_i(incr3),
        .iter_i(iter), .iter2_i(iter2), .iter3_i(iter3),
        .shift_i(shift), .shift2_i(shift2), .shift3_i(shift3),
        .valid_o(valid), .ready_i(ready), .addr_o(addr), .store_o(store), .done_o(done)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic cfg_t base_cfg();
        cfg_t c;
        c = '{default: '0};
        return c;
    endfunction

    task automatic apply_cfg(input cfg_t c);
        ign = c.ign; per = c.per; per2 = c.per2; per3 = c.per3; duty = c.duty; delay = c.delay;
        start = c.start; incr = c.incr; incr2 = c.incr2; incr3 = c.incr3;
        iter = c.iter; iter2 = c.iter2; iter3 = c.iter3;
        shift = c.shift; shift2 = c.shift2; shift3 = c.shift3;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    function automatic int z1(input logic [9:0] v);
        return (v == 10'd0) ? 1 : int'(v);
    endfunction

    // Reference: walk the six nested loops and list every beat the generator must present.
    function automatic void build(input cfg_t c);
        logic [9:0] a;
        int P1, I1, P2, I2, P3, I3;
        logic v;
        P1 = z1(c.per); I1 = z1(c.iter); P2 = z1(c.per2);
        I2 = z1(c.iter2); P3 = z1(c.per3); I3 = z1(c.iter3);
        exp_q.delete();
        for (int d = 0; d < int'(c.delay); d++) exp_q.push_back('{10'd0, 1'b0, 1'b0, 1'b0});
        if (c.ign) exp_q.push_back('{c.start, 1'b0, 1'b0, 1'b1});
        a = c.start;
        for (int i3 = 0; i3 < I3; i3++)
        for (int p3 = 0; p3 < P3; p3++)
        for (int i2 = 0; i2 < I2; i2++)
        for (int p2 = 0; p2 < P2; p2++)
        for (int i1 = 0; i1 < I1; i1++)
        for (int p1 = 0; p1 < P1; p1++) begin
`ifdef ADDRGEN3_DUTY_EN
            v = (c.duty == 10'd0) || (p1 < int'(c.duty));
`else
            v = 1'b1;
`endif
            exp_q.push_back('{a, v, (p1 == P1 - 1), 1'b1});
            if      (p1 < P1 - 1) a = a + c.incr;
            else if (i1 < I1 - 1) a = a + c.shift;
            else if (p2 < P2 - 1) a = a + c.incr2;
            else if (i2 < I2 - 1) a = a + c.shift2;
            else if (p3 < P3 - 1) a = a + c.incr3;
            else                  a = a + c.shift3;
        end
    endfunction

    // Consume exp_q against the DUT; ready is random, or held low stall_len cycles at beat stall_at.
    task automatic run_stream(input int stall_at, input int stall_len, input bit rnd, output int cyc);
        beat_t b;
        int idx = 0, st = 0;
        logic rdy;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 5000) begin
            b = exp_q[0];
            check("stream_valid", 32'(valid), 32'(b.valid));
            check("stream_store", 32'(store), 32'(b.store));
            check("stream_done_low", 32'(done), 32'd0);
            if (b.chk_addr) check("stream_addr", 32'(addr), 32'(b.addr));
            if (rnd)                                   rdy = 1'($urandom_range(0, 1));
            else if (idx == stall_at && st < stall_len) begin rdy = 1'b0; st++; end
            else                                       rdy = 1'b1;
            ready = rdy;
            if (!b.valid || rdy) begin
                void'(exp_q.pop_front());
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL stream_timeout remaining=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        check("stream_done_high", 32'(done), 32'd1);
        check("stream_valid_idle", 32'(valid), 32'd0);
        ready = 1'b1;
    endtask

    cfg_t scfg[3];
    vec_t tv[15];
    cfg_t c0, cr;
    int cyc;

    initial begin
        c0 = base_cfg();
        c0.start = 10'd4; c0.per = 10'd4; c0.incr = 10'd1; c0.iter = 10'd2; c0.shift = 10'd10;
        scfg[0] = c0;
        scfg[1] = base_cfg(); scfg[1].per = 10'd4; scfg[1].duty = 10'd2; scfg[1].iter = 10'd1; scfg[1].incr = 10'd1;
        scfg[2] = base_cfg(); scfg[2].ign = 1'b1; scfg[2].per = 10'd2; scfg[2].incr = 10'd1; scfg[2].iter = 10'd1;
        tv[0]  = '{0, 10'd4,  1'b1, 1'b0}; tv[1]  = '{0, 10'd5,  1'b1, 1'b0};
        tv[2]  = '{0, 10'd6,  1'b1, 1'b0}; tv[3]  = '{0, 10'd7,  1'b1, 1'b1};
        tv[4]  = '{0, 10'd17, 1'b1, 1'b0}; tv[5]  = '{0, 10'd18, 1'b1, 1'b0};
        tv[6]  = '{0, 10'd19, 1'b1, 1'b0}; tv[7]  = '{0, 10'd20, 1'b1, 1'b1};
        tv[8]  = '{1, 10'd0,  1'b1, 1'b0}; tv[9]  = '{1, 10'd1,  1'b1, 1'b0};
        tv[10] = '{1, 10'd2,  GAP_V, 1'b0}; tv[11] = '{1, 10'd3,  GAP_V, 1'b1};
        tv[12] = '{2, 10'd0,  1'b0, 1'b0}; tv[13] = '{2, 10'd0,  1'b1, 1'b0};
        tv[14] = '{2, 10'd1,  1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_store", 32'(store), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_done", 32'(done), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed beat tables with ready held high.
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || tv[i].scen != tv[i-1].scen) begin
                if (i != 0) check("table_done", 32'(done), 32'd1);
                apply_cfg(scfg[tv[i].scen]);
                pulse_run();
            end
            check("table_addr", 32'(addr), 32'(tv[i].addr));
            check("table_valid", 32'(valid), 32'(tv[i].valid));
            check("table_store", 32'(store), 32'(tv[i].store));
            @(negedge clk);
        end
        check("table_done", 32'(done), 32'd1);

        // Start delay of 3: three dead cycles, then the same 8 beats.
        cr = c0; cr.delay = 7'd3;
        apply_cfg(cr); build(cr); pulse_run();
        run_stream(-1, 0, 1'b0, cyc);
        check("delay_cycles", 32'(cyc), 32'd11);

        // ready_i low for 3 cycles on beat 2 stretches the run by 3.
        apply_cfg(c0); build(c0); pulse_run();
        run_stream(1, 3, 1'b0, cyc);
        check("stall_cycles", 32'(cyc), 32'd11);

        // Reset in the middle of a run, then a clean restart.
        apply_cfg(c0); pulse_run();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_done", 32'(done), 32'd1);
        check("midrst_store", 32'(store), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        build(c0); pulse_run();
        run_stream(-1, 0, 1'b0, cyc);

        // run_i while running restarts with the new configuration.
        apply_cfg(c0); pulse_run();
        repeat (2) @(negedge clk);
        apply_cfg(scfg[2]); build(scfg[2]); pulse_run();
        run_stream(-1, 0, 1'b0, cyc);

        // Randomized configurations with random backpressure.
        for (int n = 0; n < 30; n++) begin
            cr = base_cfg();
            cr.ign   = 1'($urandom_range(0, 1));
            cr.per   = 10'($urandom_range(0, 4));  cr.iter  = 10'($urandom_range(0, 3));
            cr.per2  = 10'($urandom_range(0, 3));  cr.iter2 = 10'($urandom_range(0, 2));
            cr.per3  = 10'($urandom_range(0, 2));  cr.iter3 = 10'($urandom_range(0, 2));
            cr.duty  = 10'($urandom_range(0, 5));  cr.delay = 7'($urandom_range(0, 4));
            cr.start = 10'($urandom_range(0, 1023));
            cr.incr  = 10'($urandom_range(0, 1023)); cr.shift  = 10'($urandom_range(0, 1023));
            cr.incr2 = 10'($urandom_range(0, 1023)); cr.shift2 = 10'($urandom_range(0, 1023));
            cr.incr3 = 10'($urandom_range(0, 1023)); cr.shift3 = 10'($urandom_range(0, 1023));
            apply_cfg(cr); build(cr); pulse_run();
            run_stream(-1, 0, 1'b1, cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
